// File: rtl/branch_tracker.sv
// branch_tracker: in-order queue of fetched, BTB-predicted branches.
// Entries are allocated at the tail and resolved by the functional units in
// any order. They retire strictly in order from the head. Each retire emits a
// registered BTB update. A mispredicting retire also emits a fetch redirect
// and flushes every younger entry, followed by a one-cycle FLUSH state.
module branch_tracker #(
    parameter int  BTQ_LEN = 8,
    parameter int  XLEN    = 32,
    localparam int IDXW    = $clog2(BTQ_LEN)
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            alloc_valid,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            alloc_pred_taken,
    input  logic [XLEN-1:0] alloc_pred_target,
    output logic            alloc_ready,
    output logic [IDXW-1:0] alloc_idx,

    input  logic            res_valid,
    input  logic [IDXW-1:0] res_idx,
    input  logic            res_taken,
    input  logic [XLEN-1:0] res_target,

    output logic            upd_valid,
    output logic [XLEN-1:0] upd_pc,
    output logic            upd_taken,
    output logic [XLEN-1:0] upd_target,

    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,

    output logic [IDXW:0]   count
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   head_q, head_d;
    logic [IDXW-1:0]   tail_q, tail_d;
    logic [IDXW:0]     count_q, count_d;

    logic [BTQ_LEN-1:0] busy_q, busy_d;
    logic [BTQ_LEN-1:0] resolved_q, resolved_d;
    logic [BTQ_LEN-1:0] pred_taken_q, pred_taken_d;
    logic [BTQ_LEN-1:0] act_taken_q, act_taken_d;
    logic [XLEN-1:0]    pc_q [BTQ_LEN];
    logic [XLEN-1:0]    pc_d [BTQ_LEN];
    logic [XLEN-1:0]    pred_target_q [BTQ_LEN];
    logic [XLEN-1:0]    pred_target_d [BTQ_LEN];
    logic [XLEN-1:0]    act_target_q [BTQ_LEN];
    logic [XLEN-1:0]    act_target_d [BTQ_LEN];

    logic               upd_valid_q, upd_valid_d;
    logic [XLEN-1:0]    upd_pc_q, upd_pc_d;
    logic               upd_taken_q, upd_taken_d;
    logic [XLEN-1:0]    upd_target_q, upd_target_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;

    logic               alloc_fire;
    logic               res_accept;
    logic               retire;
    logic               mispredict;

    // Ready comes only from registered state, so a retire in this cycle
    // never frees a slot for an allocation in the same cycle.
    assign alloc_ready = (state_q == RUN) && (count_q < (IDXW+1)'(BTQ_LEN));
    assign alloc_idx   = tail_q;
    assign count       = count_q;

    assign upd_valid      = upd_valid_q;
    assign upd_pc         = upd_pc_q;
    assign upd_taken      = upd_taken_q;
    assign upd_target     = upd_target_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

    // Decide which handshakes fire this cycle and whether the head mispredicted.
    always_comb begin
        alloc_fire = alloc_valid && alloc_ready;
        res_accept = (state_q == RUN) && res_valid &&
                     busy_q[res_idx] && !resolved_q[res_idx];
        retire     = (state_q == RUN) && busy_q[head_q] && resolved_q[head_q];
        mispredict = (act_taken_q[head_q] != pred_taken_q[head_q]) ||
                     (act_taken_q[head_q] &&
                      (act_target_q[head_q] != pred_target_q[head_q]));
    end

    // Next-state computation for the queue, the pointers and the output packets.
    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        busy_d        = busy_q;
        resolved_d    = resolved_q;
        pred_taken_d  = pred_taken_q;
        act_taken_d   = act_taken_q;
        pc_d          = pc_q;
        pred_target_d = pred_target_q;
        act_target_d  = act_target_q;

        upd_valid_d      = 1'b0;
        upd_pc_d         = upd_pc_q;
        upd_taken_d      = upd_taken_q;
        upd_target_d     = upd_target_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        if (state_q == FLUSH) begin
            state_d = RUN;
        end else begin
            if (res_accept) begin
                resolved_d[res_idx]   = 1'b1;
                act_taken_d[res_idx]  = res_taken;
                act_target_d[res_idx] = res_target;
            end

            if (alloc_fire) begin
                busy_d[tail_q]        = 1'b1;
                resolved_d[tail_q]    = 1'b0;
                pc_d[tail_q]          = alloc_pc;
                pred_taken_d[tail_q]  = alloc_pred_taken;
                pred_target_d[tail_q] = alloc_pred_target;
                tail_d                = tail_q + 1'b1;
            end

            if (retire) begin
                busy_d[head_q] = 1'b0;
                head_d         = head_q + 1'b1;
                upd_valid_d    = 1'b1;
                upd_pc_d       = pc_q[head_q];
                upd_taken_d    = act_taken_q[head_q];
                upd_target_d   = act_target_q[head_q];
            end

            count_d = count_q + (IDXW+1)'(alloc_fire) - (IDXW+1)'(retire);

            // A wrong-path flush discards everything younger, including
            // whatever was allocated or resolved in this very cycle.
            if (retire && mispredict) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = act_taken_q[head_q] ? act_target_q[head_q]
                                                       : pc_q[head_q] + XLEN'(4);
                busy_d           = '0;
                head_d           = '0;
                tail_d           = '0;
                count_d          = '0;
                state_d          = FLUSH;
            end
        end
    end

    // Register all state; reset returns to an empty queue in RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= RUN;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            busy_q           <= '0;
            resolved_q       <= '0;
            pred_taken_q     <= '0;
            act_taken_q      <= '0;
            pc_q             <= '{default: '0};
            pred_target_q    <= '{default: '0};
            act_target_q     <= '{default: '0};
            upd_valid_q      <= 1'b0;
            upd_pc_q         <= '0;
            upd_taken_q      <= 1'b0;
            upd_target_q     <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            busy_q           <= busy_d;
            resolved_q       <= resolved_d;
            pred_taken_q     <= pred_taken_d;
            act_taken_q      <= act_taken_d;
            pc_q             <= pc_d;
            pred_target_q    <= pred_target_d;
            act_target_q     <= act_target_d;
            upd_valid_q      <= upd_valid_d;
            upd_pc_q         <= upd_pc_d;
            upd_taken_q      <= upd_taken_d;
            upd_target_q     <= upd_target_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

endmodule

// File: tb/tb_branch_tracker.sv
// tb_branch_tracker: scoreboard bench for branch_tracker. The driver keeps a
// queue-of-branches reference model and predicts every update packet. A
// separate monitor pops those predictions when the DUT presents them.
module tb_branch_tracker;

    localparam int BTQ_LEN = 8;
    localparam int XLEN    = 32;
    localparam int IDXW    = $clog2(BTQ_LEN);

    logic            clock = 1'b0;
    logic            reset;
    logic            alloc_valid;
    logic [XLEN-1:0] alloc_pc;
    logic            alloc_pred_taken;
    logic [XLEN-1:0] alloc_pred_target;
    logic            alloc_ready;
    logic [IDXW-1:0] alloc_idx;
    logic            res_valid;
    logic [IDXW-1:0] res_idx;
    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [IDXW:0]   count;

    branch_tracker #(.BTQ_LEN(BTQ_LEN), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc),
        .alloc_pred_taken(alloc_pred_taken), .alloc_pred_target(alloc_pred_target),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .res_valid(res_valid), .res_idx(res_idx),
        .res_taken(res_taken), .res_target(res_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .count(count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    // Reference model: in-flight branches in program order, oldest first.
    typedef struct {
        int              idx;
        logic [XLEN-1:0] pc;
        logic            pt;
        logic [XLEN-1:0] ptgt;
        logic            res;
        logic            at;
        logic [XLEN-1:0] atgt;
    } entry_t;

    typedef struct {
        int              cyc;
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] tgt;
        logic            redir;
        logic [XLEN-1:0] rpc;
    } exp_t;

    entry_t mq[$];
    exp_t   sb[$];
    int     next_idx = 0;
    bit     m_flush  = 0;
    int     tests    = 0;
    int     fails    = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus plus the matching step of the reference model.
    task automatic applyStimulus(input logic av, input logic [XLEN-1:0] apc,
                                 input logic apt, input logic [XLEN-1:0] aptgt,
                                 input logic rv, input int ridx,
                                 input logic rt, input logic [XLEN-1:0] rtgt);
        bit     ready_m;
        bit     mis;
        entry_t e;
        @(negedge clock);
        #1;
        ready_m = !m_flush && (mq.size() < BTQ_LEN);
        checkOutput("alloc_ready", 64'(alloc_ready), 64'(ready_m));
        checkOutput("count", 64'(count), 64'(mq.size()));
        if (ready_m) checkOutput("alloc_idx", 64'(alloc_idx), 64'(next_idx));

        alloc_valid       = av;
        alloc_pc          = apc;
        alloc_pred_taken  = apt;
        alloc_pred_target = aptgt;
        res_valid         = rv;
        res_idx           = IDXW'(ridx);
        res_taken         = rt;
        res_target        = rtgt;

        mis = 0;
        if (m_flush) begin
            m_flush = 0;
        end else begin
            if (mq.size() > 0 && mq[0].res) begin
                e   = mq.pop_front();
                mis = (e.at != e.pt) || (e.at && e.atgt != e.ptgt);
                sb.push_back('{cyc + 1, e.pc, e.at, e.atgt, mis,
                               e.at ? e.atgt : e.pc + 32'd4});
            end
            if (rv) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].idx == ridx && !mq[i].res) begin
                        mq[i].res  = 1;
                        mq[i].at   = rt;
                        mq[i].atgt = rtgt;
                        break;
                    end
                end
            end
            if (av && ready_m) begin
                mq.push_back('{next_idx, apc, apt, aptgt, 1'b0, 1'b0, '0});
                next_idx = (next_idx + 1) % BTQ_LEN;
            end
            if (mis) begin
                mq.delete();
                next_idx = 0;
                m_flush  = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, '0, 0, 0, 0, '0);
    endtask

    task automatic alloc1(input logic [XLEN-1:0] pc, input logic pt, input logic [XLEN-1:0] ptgt);
        applyStimulus(1, pc, pt, ptgt, 0, 0, 0, '0);
    endtask

    task automatic resolve1(input int idx, input logic t, input logic [XLEN-1:0] tgt);
        applyStimulus(0, '0, 0, '0, 1, idx, t, tgt);
    endtask

    // Reset with allocation asserted, then check the whole output set.
    task automatic apply_reset();
        @(negedge clock);
        #1;
        checkOutput("pending_updates_at_reset", 64'(sb.size()), 64'd0);
        sb.delete();
        reset       = 1;
        alloc_valid = 1;
        alloc_pc    = 32'hdead_beec;
        res_valid   = 1;
        @(negedge clock);
        #1;
        reset       = 0;
        alloc_valid = 0;
        res_valid   = 0;
        mq.delete();
        next_idx = 0;
        m_flush  = 0;
        checkOutput("rst_upd_valid", 64'(upd_valid), 64'd0);
        checkOutput("rst_upd_pc", 64'(upd_pc), 64'd0);
        checkOutput("rst_upd_taken", 64'(upd_taken), 64'd0);
        checkOutput("rst_upd_target", 64'(upd_target), 64'd0);
        checkOutput("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        checkOutput("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        checkOutput("rst_alloc_idx", 64'(alloc_idx), 64'd0);
    endtask

    function automatic int pick_unresolved();
        int cand[$];
        for (int i = 0; i < mq.size(); i++) if (!mq[i].res) cand.push_back(i);
        if (cand.size() == 0) return -1;
        return cand[$urandom_range(0, cand.size() - 1)];
    endfunction

    // Resolve everything as predicted until the model queue is empty.
    task automatic drain_all();
        int u;
        for (int i = 0; i < 4 * BTQ_LEN && (mq.size() > 0 || m_flush); i++) begin
            u = pick_unresolved();
            if (u >= 0) resolve1(mq[u].idx, mq[u].pt, mq[u].ptgt);
            else idle(1);
        end
        checkOutput("drain_left", 64'(mq.size()), 64'd0);
        idle(2);
    endtask

    // Monitor: compare every presented update against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (upd_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_upd_pc", 64'(upd_pc), 64'hffff_ffff_ffff_ffff);
                end else begin
                    e = sb.pop_front();
                    checkOutput("upd_cycle", 64'(cyc), 64'(e.cyc));
                    checkOutput("upd_pc", 64'(upd_pc), 64'(e.pc));
                    checkOutput("upd_taken", 64'(upd_taken), 64'(e.taken));
                    checkOutput("upd_target", 64'(upd_target), 64'(e.tgt));
                    checkOutput("redirect_valid", 64'(redirect_valid), 64'(e.redir));
                    if (e.redir) checkOutput("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
                end
            end else begin
                if (redirect_valid === 1'b1)
                    checkOutput("redirect_without_upd", 64'(redirect_valid), 64'd0);
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    checkOutput("missing_upd_pc", 64'(upd_valid), 64'(e.pc));
                end
            end
        end
    end

    // Hard time limit so the run can never hang.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized phase.
    initial begin
        logic            av, apt, rv, rt;
        logic [XLEN-1:0] apc, aptgt, rtgt;
        int              ridx, u, base;

        reset = 1; alloc_valid = 0; alloc_pc = '0; alloc_pred_taken = 0;
        alloc_pred_target = '0; res_valid = 0; res_idx = '0; res_taken = 0;
        res_target = '0;
        apply_reset();

        // Correctly predicted taken branch.
        alloc1(32'h100, 1, 32'h200);
        resolve1(0, 1, 32'h200);
        idle(3);

        // Fill the queue, try a ninth allocation, then free one slot.
        for (int i = 0; i < BTQ_LEN + 1; i++) alloc1(32'h1000 + 32'(4 * i), 0, 32'h0);
        resolve1(mq[0].idx, mq[0].pt, mq[0].ptgt);
        idle(2);
        drain_all();

        // Out-of-order resolution still retires in program order.
        for (int i = 0; i < 3; i++) alloc1(32'h2000 + 32'(4 * i), 0, 32'h0);
        resolve1(mq[2].idx, 0, 32'h0);
        resolve1(mq[1].idx, 0, 32'h0);
        resolve1(mq[0].idx, 0, 32'h0);
        idle(5);

        // Predicted taken, actually not taken: redirect to pc+4 and flush.
        alloc1(32'h40, 1, 32'h80);
        resolve1(mq[0].idx, 0, 32'h0);
        idle(4);

        // Resolving an already-resolved entry or an idle slot is ignored.
        alloc1(32'h300, 0, 32'h0);
        alloc1(32'h304, 0, 32'h0);
        base = mq[1].idx;
        resolve1(base, 0, 32'h0);
        resolve1(base, 1, 32'h999);
        resolve1((base + 3) % BTQ_LEN, 1, 32'h777);
        resolve1(mq[0].idx, 0, 32'h0);
        idle(4);

        // Fill with tail wrap, mispredict at head, reset during FLUSH.
        for (int i = 0; i < BTQ_LEN; i++) alloc1(32'h4000 + 32'(4 * i), 0, 32'h0);
        resolve1(mq[0].idx, 1, 32'h500);
        idle(1);
        apply_reset();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                apply_reset();
                continue;
            end
            av    = ($urandom_range(0, 99) < 55);
            apc   = $urandom & ~32'h3;
            apt   = 1'($urandom_range(0, 1));
            aptgt = $urandom & ~32'h3;
            rv = 0; ridx = 0; rt = 0; rtgt = '0;
            u = pick_unresolved();
            if (u >= 0 && $urandom_range(0, 99) < 70) begin
                rv   = 1;
                ridx = mq[u].idx;
                if ($urandom_range(0, 99) < 88) begin
                    rt   = mq[u].pt;
                    rtgt = mq[u].pt ? mq[u].ptgt : ($urandom & ~32'h3);
                end else begin
                    rt   = 1'($urandom_range(0, 1));
                    rtgt = $urandom & ~32'h3;
                end
            end else if ($urandom_range(0, 99) < 20) begin
                rv   = 1;
                ridx = $urandom_range(0, BTQ_LEN - 1);
                rt   = 1'($urandom_range(0, 1));
                rtgt = $urandom & ~32'h3;
            end
            applyStimulus(av, apc, apt, aptgt, rv, ridx, rt, rtgt);
        end

        drain_all();
        idle(3);
        checkOutput("final_pending_updates", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
